// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 keyboard receiver with a first-word-fall-through scan
//               code queue. PS2_CLK and PS2_DAT are synchronised into clk,
//               PS2_CLK is glitch-filtered, and each filtered falling edge
//               becomes a one-cycle sample strobe. Frames are checked for
//               start, odd parity and stop bits and abandoned on a stall.
//               Good scan codes are queued for the CPU keyboard register.
// Ports       :
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   PS2_CLK       in   raw PS/2 clock (asynchronous)
//   PS2_DAT       in   raw PS/2 data (asynchronous)
//   rd_en         in   pop the FIFO head (ignored while empty)
//   scanCode      out  FIFO head, 0 while empty
//   scanCodeValid out  FIFO not empty
//   fifoCount     out  number of entries held
//   frameError    out  one-cycle pulse: frame rejected or timed out
//   overflow      out  one-cycle pulse: good frame dropped, FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
   parameter int FILTER_CYCLES  = 800,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 8,
   parameter int PARITY_CHECK   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          PS2_CLK,
   input  logic                          PS2_DAT,
   input  logic                          rd_en,
   output logic [7:0]                    scanCode,
   output logic                          scanCodeValid,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
   output logic                          frameError,
   output logic                          overflow
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_FILT_W = $clog2(FILTER_CYCLES);
   localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES);
   localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W  = c_ADDR_W + 1;

   localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_CYCLES - 1);
   localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]          c_LAST_BIT  = 4'd7;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Two-flop synchronisers. Both lines idle high, so reset to 1 to avoid a
   // false falling edge when reset is released.
   // -------------------------------------------------------------------------
   logic r_clk_s1, r_clk_s2;
   logic r_dat_s1, r_dat_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= PS2_CLK;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= PS2_DAT;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // -------------------------------------------------------------------------
   // Glitch filter: the synchronised clock must differ from the filtered
   // level on FILTER_CYCLES consecutive cycles before the filtered level
   // follows it. Any return to the filtered level restarts the count.
   // -------------------------------------------------------------------------
   logic                r_filt_clk;
   logic                r_filt_prev;
   logic [c_FILT_W-1:0] r_filt_cnt;
   logic                w_strobe;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt_clk  <= 1'b1;
         r_filt_prev <= 1'b1;
         r_filt_cnt  <= '0;
      end else begin
         r_filt_prev <= r_filt_clk;
         if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == c_FILT_LAST) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end
      end
   end

   // High for exactly the one cycle after the filtered clock falls.
   assign w_strobe = r_filt_prev & ~r_filt_clk;

   // -------------------------------------------------------------------------
   // Frame FSM and timeout
   // -------------------------------------------------------------------------
   state_t             r_state, w_state_nxt;
   logic [3:0]         r_bitcnt, w_bitcnt_nxt;
   logic [7:0]         r_shift, w_shift_nxt;
   logic               r_parity, w_parity_nxt;
   logic [c_TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
   logic               r_frame_err, w_frame_err_nxt;
   logic               r_overflow, w_overflow_nxt;
   logic               w_frame_done;
   logic               w_frame_good;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_parity    <= 1'b0;
         r_tmo_cnt   <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_shift     <= w_shift_nxt;
         r_parity    <= w_parity_nxt;
         r_tmo_cnt   <= w_tmo_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_overflow  <= w_overflow_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_bitcnt_nxt    = r_bitcnt;
      w_shift_nxt     = r_shift;
      w_parity_nxt    = r_parity;
      w_tmo_nxt       = r_tmo_cnt;
      w_frame_err_nxt = 1'b0;
      w_frame_done    = 1'b0;
      w_frame_good    = 1'b0;

      case (r_state)
         S_IDLE: begin
            // A high sample on a strobe is just line idle, not an error.
            if (w_strobe && !r_dat_s2) begin
               w_state_nxt  = S_DATA;
               w_bitcnt_nxt = '0;
            end
         end
         S_DATA: begin
            if (w_strobe) begin
               w_shift_nxt  = {r_dat_s2, r_shift[7:1]};   // LSB arrives first
               w_bitcnt_nxt = r_bitcnt + 1'b1;
               if (r_bitcnt == c_LAST_BIT) begin
                  w_state_nxt = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (w_strobe) begin
               w_parity_nxt = r_dat_s2;
               w_state_nxt  = S_STOP;
            end
         end
         S_STOP: begin
            if (w_strobe) begin
               w_frame_done    = 1'b1;
               // Odd parity: XOR over data and parity bit must be 1.
               w_frame_good    = r_dat_s2 &
                                 ((PARITY_CHECK == 0) || (^{r_shift, r_parity}));
               w_frame_err_nxt = ~w_frame_good;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Stall detection inside a frame; a strobe always wins over expiry.
      if (r_state == S_IDLE) begin
         w_tmo_nxt = '0;
      end else if (w_strobe) begin
         w_tmo_nxt = '0;
      end else if (r_tmo_cnt == c_TMO_LAST) begin
         w_state_nxt     = S_IDLE;
         w_frame_err_nxt = 1'b1;
         w_tmo_nxt       = '0;
      end else begin
         w_tmo_nxt = r_tmo_cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // First-word-fall-through FIFO
   // -------------------------------------------------------------------------
   logic [7:0]          r_mem [0:FIFO_DEPTH-1];
   logic [c_ADDR_W-1:0] r_wptr, r_rptr;
   logic [c_CNT_W-1:0]  r_count;
   logic                w_full, w_empty;
   logic                w_push, w_pop;
   logic                w_good;

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == '0);
   assign w_good  = w_frame_done & w_frame_good;
   assign w_pop   = rd_en & ~w_empty;
   // A full FIFO can still take the byte if the head leaves on the same edge.
   assign w_push  = w_good & (~w_full | rd_en);

   always_comb begin
      w_overflow_nxt = w_good & w_full & ~rd_en;
   end

   // Storage carries no reset; the head is masked while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= r_shift;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         // Depth is a power of two, so pointers wrap by natural overflow.
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      scanCode      = w_empty ? 8'h00 : r_mem[r_rptr];
      scanCodeValid = ~w_empty;
      fifoCount     = r_count;
      frameError    = r_frame_err;
      overflow      = r_overflow;
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Self-checking bench for ps2_rx_fifo. Two instances share the
//               PS/2 lines and rd_en: one with parity checking, one without.
//               A frame-level queue model predicts contents, error and
//               overflow pulse counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

   localparam int FILT  = 4;
   localparam int TMO   = 200;
   localparam int DEPTH = 4;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       rd_en   = 1'b0;

   logic [7:0] code0, code1;
   logic       valid0, valid1;
   logic [2:0] cnt0, cnt1;
   logic       err0, err1;
   logic       ovf0, ovf1;

   ps2_rx_fifo #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO),
                 .FIFO_DEPTH(DEPTH), .PARITY_CHECK(1)) dut (
      .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .rd_en(rd_en), .scanCode(code0), .scanCodeValid(valid0),
      .fifoCount(cnt0), .frameError(err0), .overflow(ovf0));

   ps2_rx_fifo #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO),
                 .FIFO_DEPTH(DEPTH), .PARITY_CHECK(0)) dut_np (
      .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .rd_en(rd_en), .scanCode(code1), .scanCodeValid(valid1),
      .fifoCount(cnt1), .frameError(err1), .overflow(ovf1));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int err_hi = 0, ovf_hi = 0;
   int last_err_cyc = 0, last_fall_cyc = 0;

   // Reference model: queues per instance plus expected pulse-cycle counts.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int exp_err = 0, exp_ovf = 0;

   always @(posedge clk) cyc++;

   // Counts high cycles, so a pulse wider than one cycle shows up as extra.
   always @(negedge clk) begin
      if (!rst) begin
         if (err0) begin
            err_hi++;
            last_err_cyc = cyc;
         end
         if (ovf0) ovf_hi++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".cnt"},   32'(cnt0),   32'(q0.size()));
      check({tag, ".valid"}, 32'(valid0), 32'(q0.size() != 0));
      check({tag, ".head"},  32'(code0),  (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
      check({tag, ".err"},   32'(err_hi), 32'(exp_err));
      check({tag, ".ovf"},   32'(ovf_hi), 32'(exp_ovf));
      check({tag, ".np_cnt"},  32'(cnt1),  32'(q1.size()));
      check({tag, ".np_head"}, 32'(code1), (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
   endtask

   // Frame-level model: optional pop on the deciding edge, then the push.
   task automatic model_frame(input logic [7:0] d, input logic par_ok,
                              input logic stop_ok, input logic pop);
      if (pop) begin
         if (q0.size() != 0) void'(q0.pop_front());
         if (q1.size() != 0) void'(q1.pop_front());
      end
      if (stop_ok && par_ok) begin
         if (q0.size() == DEPTH) exp_ovf++;
         else                    q0.push_back(d);
      end else begin
         exp_err++;
      end
      if (stop_ok && q1.size() < DEPTH) q1.push_back(d);
   endtask

   // Drives nbits of an 11-bit frame, 40 clk per bit (20 high, 20 low).
   // Data changes mid high phase; glitch adds a 2-cycle low pulse on bit 4.
   // pop_at_stop raises rd_en on the strobe cycle of the stop bit: two
   // synchroniser stages plus FILT filter cycles after the pin falls.
   task automatic send_frame(input logic [7:0] d, input logic par_flip,
                             input logic stop_val, input int nbits,
                             input logic glitch, input logic pop_at_stop);
      logic [10:0] bits;
      bits = {stop_val, (~^d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_dat = bits[i];
         repeat (4) @(negedge clk);
         if (glitch && i == 4) ps2_clk = 1'b0;
         repeat (2) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (4) @(negedge clk);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         if (pop_at_stop && i == 10) begin
            repeat (FILT + 2) @(posedge clk);
            @(negedge clk) rd_en = 1'b1;
            @(negedge clk) rd_en = 1'b0;
            repeat (18) @(negedge clk);
         end else begin
            repeat (20) @(negedge clk);
         end
         ps2_clk = 1'b1;
         repeat (9) @(negedge clk);
      end
   endtask

   task automatic pop_one();
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
      if (q0.size() != 0) void'(q0.pop_front());
      if (q1.size() != 0) void'(q1.pop_front());
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 2 * DEPTH && (q0.size() != 0 || q1.size() != 0); k++) begin
         pop_one();
         check_state(tag);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       pf, sb, gl;
      int         e0, npop;

      // ---- reset ----
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst.err_pin", 32'(err0), 32'h0);
      check("rst.ovf_pin", 32'(ovf0), 32'h0);
      check_state("rst");

      // ---- three good frames ----
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0); model_frame(8'h1C, 1, 1, 0);
      send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, 1'b0); model_frame(8'hF0, 1, 1, 0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0); model_frame(8'h1C, 1, 1, 0);
      check("three.cnt_abs", 32'(cnt0), 32'd3);
      check_state("three");
      drain("three_pop");

      // ---- bad parity: rejected with checking, queued without ----
      send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0); model_frame(8'h1C, 0, 1, 0);
      check_state("badpar");
      drain("badpar_pop");

      // ---- glitched frame accepted, stop-0 frame rejected ----
      send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b1, 1'b0); model_frame(8'h5A, 1, 1, 0);
      check("glitch.head_abs", 32'(code0), 32'h5A);
      check_state("glitch");
      send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0, 1'b0); model_frame(8'h33, 1, 0, 0);
      check_state("stop0");
      drain("stop0_pop");

      // ---- overflow on the fifth frame ----
      for (int n = 1; n <= 5; n++) begin
         send_frame(8'(n), 1'b0, 1'b1, 11, 1'b0, 1'b0);
         model_frame(8'(n), 1, 1, 0);
      end
      check("ovf.cnt_abs", 32'(cnt0), 32'd4);
      check_state("ovf");
      drain("ovf_pop");
      check("ovf.valid_after", 32'(valid0), 32'h0);

      // ---- push into full FIFO with simultaneous pop ----
      for (int n = 1; n <= 4; n++) begin
         send_frame(8'(n), 1'b0, 1'b1, 11, 1'b0, 1'b0);
         model_frame(8'(n), 1, 1, 0);
      end
      send_frame(8'h05, 1'b0, 1'b1, 11, 1'b0, 1'b1); model_frame(8'h05, 1, 1, 1);
      check("fullpop.head_abs", 32'(code0), 32'h02);
      check_state("fullpop");
      drain("fullpop_pop");

      // ---- timeout after three data bits ----
      e0 = err_hi;
      send_frame(8'hFF, 1'b0, 1'b1, 4, 1'b0, 1'b0);
      ps2_dat = 1'b1;
      for (int k = 0; k < 2 * TMO && err_hi == e0; k++) @(negedge clk);
      @(negedge clk);
      exp_err++;
      check("tmo.seen", 32'(err_hi), 32'(e0 + 1));
      // pin fall -> strobe edge is 2 + FILT + 1 edges, then TMO more edges
      check("tmo.delay", 32'(last_err_cyc - last_fall_cyc), 32'(TMO + FILT + 3));
      send_frame(8'h2A, 1'b0, 1'b1, 11, 1'b0, 1'b0); model_frame(8'h2A, 1, 1, 0);
      check_state("after_tmo");

      // ---- randomized frames with random pops ----
      for (int n = 0; n < 30; n++) begin
         d  = 8'($urandom);
         pf = ($urandom_range(0, 7) == 0);
         sb = ($urandom_range(0, 7) != 0);
         gl = 1'($urandom_range(0, 1));
         send_frame(d, pf, sb, 11, gl, 1'b0);
         model_frame(d, !pf, sb, 0);
         check_state("rnd");
         npop = $urandom_range(0, 1);
         for (int p = 0; p < npop; p++) pop_one();
         if (npop != 0) check_state("rnd_pop");
      end

      // ---- reset in the middle of a frame ----
      if (q0.size() == 0) begin
         send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0, 1'b0); model_frame(8'h44, 1, 1, 0);
      end
      send_frame(8'h66, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      ps2_dat = 1'b1;
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      q0.delete();
      q1.delete();
      check("midrst.code",  32'(code0),  32'h0);
      check("midrst.valid", 32'(valid0), 32'h0);
      check("midrst.cnt",   32'(cnt0),   32'h0);
      check("midrst.err",   32'(err0),   32'h0);
      check("midrst.ovf",   32'(ovf0),   32'h0);
      rst = 1'b0;
      repeat (TMO + 100) @(negedge clk);
      check_state("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
